sat_counter_predictor: RTL and testbench
========================================

// Module: sat_counter_predictor
// PURPOSE
//  Parametrised table of N-bit saturating counters for conditional-branch direction prediction.
//  Table index: bimodal (PC low bits) or gshare (PC XOR global history).
//  Saturating update is computed internally, in a 2-stage commit pipeline with hazard forwarding.
//  Table is initialised by an internal sweep FSM, not a parallel reset.
//  Sits between fetch (predict port) and commit (update port).
// PARAMETERS
//  PC_W      10   width of incoming branch PC
//  IDX_W     10   table index width; DEPTH = 2**IDX_W entries
//  CTR_W     2    counter width; CTR_MAX = 2**CTR_W-1
//  HIST_W    0    global history bits XORed into index (0 = bimodal; legal 0..IDX_W)
//  RESET_VAL 1    initial counter value (default weakly not-taken = 2**(CTR_W-1)-1)
// PORTS
//  clk            in   1      clock
//  rstn           in   1      reset, asynchronous, active-low
//  init_done      out  1      1 = table initialised, ports live
//  pred_valid     in   1      predict request this cycle
//  pred_pc        in   PC_W   PC to predict
//  pred_out_valid out  1      prediction result valid (1 cycle after request)
//  pred_taken     out  1      predicted direction (counter MSB)
//  pred_ctr       out  CTR_W  counter value used
//  pred_idx       out  IDX_W  table index used; carried to commit
//  upd_valid      in   1      commit update this cycle
//  upd_idx        in   IDX_W  index returned from pred_idx
//  upd_taken      in   1      resolved direction
// BEHAVIOUR
//  Reset (async):
//   - state=INIT, sweep_idx=0, GHR=0, U1/U2 stages invalid.
//   - All outputs 0: init_done, pred_out_valid, pred_taken, pred_ctr, pred_idx.
//  INIT:
//   - Each cycle writes table[sweep_idx]=RESET_VAL and increments sweep_idx.
//   - After writing DEPTH-1: state=READY; init_done=1 on the following cycle (exactly DEPTH cycles after rstn rises).
//   - pred_valid and upd_valid are ignored; nothing is queued.
//  READY is terminal. Only rstn returns the FSM to INIT.
//  Reset mid-operation:
//   - Immediate return to INIT; in-flight predictions and updates are lost.
//   - Table contents don't-care until the sweep completes.
//  Index:
//   - idx = pred_pc[IDX_W-1:0] ^ {{(IDX_W-HIST_W){0}}, GHR}.
//   - If PC_W < IDX_W, the PC is zero-extended.
//  Predict (latency 1):
//   - pred_valid at cycle N -> at N+1: pred_out_valid=1, pred_ctr=table[idx], pred_taken=pred_ctr[CTR_W-1], pred_idx=idx.
//   - pred_out_valid is 0 when there was no request.
//   - Other result outputs hold their last value when not updated.
//  Update pipeline:
//   - U1 (cycle of upd_valid): capture idx and taken; read table[upd_idx].
//   - U1 forwarding: if U2 is writing the same idx this cycle, U1 uses U2's new value.
//   - U1 shifts GHR: GHR <= {GHR[HIST_W-2:0], upd_taken}. No GHR exists when HIST_W=0.
//   - U2 (next cycle) writes next = taken ? (ctr==CTR_MAX ? ctr : ctr+1) : (ctr==0 ? 0 : ctr-1).
//   - Arithmetic is CTR_W bits; saturation is checked before increment/decrement, so no wrap.
//  Hazards:
//   - Back-to-back updates to the same idx are fully accumulated via U2->U1 forwarding.
//   - Predict read in the same cycle as a U2 write to the same idx returns the new value (write-first bypass).
//  Throughput: one predict and one update accepted every cycle, independently.
//  GHR timing: a GHR change becomes visible to index computation in the cycle after U1.
// TESTING
//  1. Release rstn with pred_valid held at 1 -> init_done rises exactly 1024 cycles later; pred_out_valid stays 0 throughout.
//  2. After init, predict pred_pc=0x155 -> next cycle: pred_out_valid=1, pred_ctr=1, pred_taken=0, pred_idx=0x155.
//  3. Four back-to-back upd_taken=1 at idx 5 -> counter 1->2->3->3 (saturates); then predict pc=5 -> pred_ctr=3, pred_taken=1.
//  4. Four back-to-back upd_taken=0 at idx 5 -> counter reaches 0 with no wrap. Issue predict pc=5 in the same cycle as the final U2 write -> pred_ctr=0.
//  5. HIST_W=4; updates T,T,N,T at idx 9 -> GHR=4'b1101; predict pc=0 -> pred_idx=0x00D, pred_ctr=1.
//  6. Assert rstn low at sweep_idx=300, release -> init_done again exactly 1024 cycles after release; all entries read back as 1.

Source files
------------

// File: rtl/sat_counter_predictor_if.sv
// Fetch/commit-facing signal bundle of the branch direction predictor.
// The predictor binds to the slave modport; the fetch/commit side binds to master.
interface sat_counter_predictor_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
);
    logic             init_done;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_out_valid;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        input  init_done, pred_out_valid, pred_taken, pred_ctr, pred_idx,
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken
    );

    modport slave (
        output init_done, pred_out_valid, pred_taken, pred_ctr, pred_idx,
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken
    );
endinterface

// File: rtl/sat_counter_predictor.sv
// Table of saturating counters for branch direction prediction (bimodal or gshare index),
// with a 2-stage forwarded update pipeline and a sweep FSM that initialises the table.
module sat_counter_predictor #(
    parameter int PC_W      = 10,
    parameter int IDX_W     = 10,
    parameter int CTR_W     = 2,
    parameter int HIST_W    = 0,
    parameter int RESET_VAL = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    sat_counter_predictor_if.slave  bus
);
    localparam int               DEPTH    = 2**IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(RESET_VAL);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_sweep_idx, w_sweep_next;
    logic             w_sweep_we;
    logic             w_ready;

    logic [CTR_W-1:0] r_table [DEPTH];

    logic             r_u1_valid;
    logic [IDX_W-1:0] r_u1_idx;
    logic             r_u1_taken;
    logic [CTR_W-1:0] r_u1_ctr;
    logic [CTR_W-1:0] w_u2_next;

    logic [IDX_W-1:0] w_hist;
    logic [IDX_W-1:0] w_pred_idx;
    logic [CTR_W-1:0] w_pred_rd;
    logic [CTR_W-1:0] w_upd_rd;

    logic             r_pred_out_valid;
    logic             r_pred_taken;
    logic [CTR_W-1:0] r_pred_ctr;
    logic [IDX_W-1:0] r_pred_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sweep_idx <= w_sweep_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep_idx;
        w_sweep_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_we   = 1'b1;
                w_sweep_next = r_sweep_idx + IDX_W'(1);
                if (r_sweep_idx == '1) w_state_next = ST_READY;
            end
            default: ;
        endcase
    end

    assign w_ready = (r_state == ST_READY);

    // Global history only exists in gshare mode; a new outcome steers the index from the next cycle.
    generate
        if (HIST_W > 0) begin : g_ghr
            logic [HIST_W-1:0] r_ghr;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)                          r_ghr <= '0;
                else if (w_ready && bus.upd_valid)  r_ghr <= HIST_W'({r_ghr, bus.upd_taken});
            end
            assign w_hist = IDX_W'(r_ghr);
        end else begin : g_no_ghr
            assign w_hist = '0;
        end
    endgenerate

    assign w_pred_idx = IDX_W'(bus.pred_pc) ^ w_hist;

    // U2 result is forwarded to both readers so same-index traffic sees the freshest count.
    assign w_pred_rd = (r_u1_valid && r_u1_idx == w_pred_idx) ? w_u2_next : r_table[w_pred_idx];
    assign w_upd_rd  = (r_u1_valid && r_u1_idx == bus.upd_idx) ? w_u2_next : r_table[bus.upd_idx];

    always_comb begin
        w_u2_next = r_u1_ctr;
        if (r_u1_taken) begin
            if (r_u1_ctr != CTR_MAX) w_u2_next = r_u1_ctr + CTR_W'(1);
        end else begin
            if (r_u1_ctr != '0)      w_u2_next = r_u1_ctr - CTR_W'(1);
        end
    end

    // NOTE: the table has no reset; the INIT sweep fills it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (w_sweep_we)      r_table[r_sweep_idx] <= INIT_CTR;
        else if (r_u1_valid) r_table[r_u1_idx]    <= w_u2_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_u1_valid <= 1'b0;
            r_u1_idx   <= '0;
            r_u1_taken <= 1'b0;
            r_u1_ctr   <= '0;
        end else begin
            r_u1_valid <= w_ready && bus.upd_valid;
            if (w_ready && bus.upd_valid) begin
                r_u1_idx   <= bus.upd_idx;
                r_u1_taken <= bus.upd_taken;
                r_u1_ctr   <= w_upd_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pred_out_valid <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_ctr       <= '0;
            r_pred_idx       <= '0;
        end else begin
            r_pred_out_valid <= w_ready && bus.pred_valid;
            if (w_ready && bus.pred_valid) begin
                r_pred_ctr   <= w_pred_rd;
                r_pred_taken <= w_pred_rd[CTR_W-1];
                r_pred_idx   <= w_pred_idx;
            end
        end
    end

    assign bus.init_done      = w_ready;
    assign bus.pred_out_valid = r_pred_out_valid;
    assign bus.pred_taken     = r_pred_taken;
    assign bus.pred_ctr       = r_pred_ctr;
    assign bus.pred_idx       = r_pred_idx;
endmodule

// File: tb/tb_sat_counter_predictor.sv
// Drives a bimodal and a gshare (HIST_W=4) predictor with the same stimulus and checks both
// against an architectural model: a predict sees every update issued in earlier cycles.
module tb_sat_counter_predictor;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       rstn;
    logic       t_pred_valid;
    logic [9:0] t_pred_pc;
    logic       t_upd_valid;
    logic [9:0] t_upd_idx;
    logic       t_upd_taken;

    int n_checks = 0;
    int n_errors = 0;

    sat_counter_predictor_if #(.PC_W(10), .IDX_W(10), .CTR_W(2)) if0 ();
    sat_counter_predictor_if #(.PC_W(10), .IDX_W(10), .CTR_W(2)) if1 ();

    assign if0.pred_valid = t_pred_valid;
    assign if0.pred_pc    = t_pred_pc;
    assign if0.upd_valid  = t_upd_valid;
    assign if0.upd_idx    = t_upd_idx;
    assign if0.upd_taken  = t_upd_taken;
    assign if1.pred_valid = t_pred_valid;
    assign if1.pred_pc    = t_pred_pc;
    assign if1.upd_valid  = t_upd_valid;
    assign if1.upd_idx    = t_upd_idx;
    assign if1.upd_taken  = t_upd_taken;

    sat_counter_predictor #(.PC_W(10), .IDX_W(10), .CTR_W(2), .HIST_W(0), .RESET_VAL(1))
        u_dut_bim (.clk(clk), .rstn(rstn), .bus(if0));
    sat_counter_predictor #(.PC_W(10), .IDX_W(10), .CTR_W(2), .HIST_W(4), .RESET_VAL(1))
        u_dut_gsh (.clk(clk), .rstn(rstn), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: counters, history, expected registered outputs per instance.
    int m_tbl [2][DEPTH];
    int m_ghr   = 0;
    int m_cnt   = 0;
    bit m_ready = 1'b0;
    int e_ov  [2] = '{0, 0};
    int e_tk  [2] = '{0, 0};
    int e_ctr [2] = '{0, 0};
    int e_idx [2] = '{0, 0};

    always @(posedge clk or negedge rstn) begin : model
        int ix;
        int c;
        if (!rstn) begin
            m_cnt = 0; m_ready = 1'b0; m_ghr = 0;
            for (int k = 0; k < 2; k++) begin
                e_ov[k] = 0; e_tk[k] = 0; e_ctr[k] = 0; e_idx[k] = 0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < DEPTH; i++) m_tbl[k][i] = 1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_ov[k] = int'(t_pred_valid);
                if (t_pred_valid) begin
                    ix = (k == 1) ? (int'(t_pred_pc) ^ m_ghr) : int'(t_pred_pc);
                    e_idx[k] = ix;
                    e_ctr[k] = m_tbl[k][ix];
                    e_tk[k]  = (m_tbl[k][ix] >= 2) ? 1 : 0;
                end
                if (t_upd_valid) begin
                    c = m_tbl[k][t_upd_idx];
                    if (t_upd_taken) c = (c < 3) ? c + 1 : 3;
                    else             c = (c > 0) ? c - 1 : 0;
                    m_tbl[k][t_upd_idx] = c;
                end
            end
            if (t_upd_valid) m_ghr = (m_ghr * 2 + int'(t_upd_taken)) % 16;
        end
    end

    always @(negedge clk) begin : compare
        check("bim.init_done",  32'(if0.init_done),      32'(m_ready));
        check("bim.out_valid",  32'(if0.pred_out_valid), e_ov[0]);
        check("bim.taken",      32'(if0.pred_taken),     e_tk[0]);
        check("bim.ctr",        32'(if0.pred_ctr),       e_ctr[0]);
        check("bim.idx",        32'(if0.pred_idx),       e_idx[0]);
        check("gsh.init_done",  32'(if1.init_done),      32'(m_ready));
        check("gsh.out_valid",  32'(if1.pred_out_valid), e_ov[1]);
        check("gsh.taken",      32'(if1.pred_taken),     e_tk[1]);
        check("gsh.ctr",        32'(if1.pred_ctr),       e_ctr[1]);
        check("gsh.idx",        32'(if1.pred_idx),       e_idx[1]);
    end

    // Counts rising edges until init_done; also flags any pred_out_valid seen meanwhile.
    task automatic wait_init(output int cycles, output int saw_ov);
        cycles = 0;
        saw_ov = 0;
        while (if0.init_done !== 1'b1 && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (if0.pred_out_valid !== 1'b0 || if1.pred_out_valid !== 1'b0) saw_ov = 1;
        end
        t_pred_valid = 1'b0;
    endtask

    task automatic do_pred(input logic [9:0] pc);
        @(negedge clk);
        t_pred_valid = 1'b1;
        t_pred_pc    = pc;
        @(negedge clk);
        t_pred_valid = 1'b0;
    endtask

    task automatic do_upd(input logic [9:0] idx, input logic taken);
        @(negedge clk);
        t_upd_valid = 1'b1;
        t_upd_idx   = idx;
        t_upd_taken = taken;
    endtask

    // Predict issued in the cycle right after the last update, i.e. during its U2 write.
    task automatic pred_after_upd(input logic [9:0] pc);
        @(negedge clk);
        t_upd_valid  = 1'b0;
        t_pred_valid = 1'b1;
        t_pred_pc    = pc;
        @(negedge clk);
        t_pred_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int saw;
        int bad;
        rstn = 1'b0;
        t_pred_valid = 1'b0; t_pred_pc = '0;
        t_upd_valid  = 1'b0; t_upd_idx = '0; t_upd_taken = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.init_done", 32'(if0.init_done), 32'd0);
        check("reset.pred_ctr",  32'(if0.pred_ctr),  32'd0);

        // Release reset with a predict request held high throughout the sweep.
        t_pred_valid = 1'b1;
        t_pred_pc    = 10'h0AA;
        #2 rstn = 1'b1;
        wait_init(lat, saw);
        check("init_latency", lat, 32'd1024);
        check("init_no_pred_out", saw, 32'd0);

        do_pred(10'h155);
        check("p155.valid", 32'(if0.pred_out_valid), 32'd1);
        check("p155.ctr",   32'(if0.pred_ctr),       32'd1);
        check("p155.taken", 32'(if0.pred_taken),     32'd0);
        check("p155.idx",   32'(if0.pred_idx),       32'h155);

        for (int i = 0; i < 4; i++) do_upd(10'd5, 1'b1);
        pred_after_upd(10'd5);
        check("sat_hi.ctr",   32'(if0.pred_ctr),   32'd3);
        check("sat_hi.taken", 32'(if0.pred_taken), 32'd1);

        for (int i = 0; i < 4; i++) do_upd(10'd5, 1'b0);
        pred_after_upd(10'd5);
        check("sat_lo.ctr",   32'(if0.pred_ctr),   32'd0);
        check("sat_lo.taken", 32'(if0.pred_taken), 32'd0);

        // Random traffic, concentrated on few indices to exercise forwarding and bypass.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            t_pred_valid = ($urandom_range(0, 3) != 0);
            t_pred_pc    = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            t_upd_valid  = ($urandom_range(0, 3) != 0);
            t_upd_idx    = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            t_upd_taken  = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        t_pred_valid = 1'b0;
        t_upd_valid  = 1'b0;

        // Reset again, then abort the sweep part-way with a second reset.
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (300) @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        wait_init(lat, saw);
        check("reinit_latency", lat, 32'd1024);

        bad = 0;
        for (int pc = 0; pc < DEPTH; pc++) begin
            @(negedge clk);
            if (pc > 0 && if0.pred_ctr !== 2'd1) bad++;
            t_pred_valid = 1'b1;
            t_pred_pc    = 10'(pc);
        end
        @(negedge clk);
        t_pred_valid = 1'b0;
        if (if0.pred_ctr !== 2'd1) bad++;
        check("readback_not_one", bad, 32'd0);

        // gshare: history T,T,N,T gives GHR=1101, so pc 0 maps to index 0x00D.
        do_upd(10'd9, 1'b1);
        do_upd(10'd9, 1'b1);
        do_upd(10'd9, 1'b0);
        do_upd(10'd9, 1'b1);
        pred_after_upd(10'd0);
        check("gsh.hist_idx", 32'(if1.pred_idx), 32'h00D);
        check("gsh.hist_ctr", 32'(if1.pred_ctr), 32'd1);
        check("bim.pc0_idx",  32'(if0.pred_idx), 32'h000);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
